// File: rtl/dev_gpo_pulse.sv
// Wishbone general-purpose output port with atomic set/clear/toggle writes,
// auto-clearing timed pulses on any bit, and full register readback.
module dev_gpo_pulse #(
    parameter int W         = 8,
    parameter int CW        = 16,
    parameter int PULSE_DEF = 1000
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CYC,
    input  logic          STB,
    input  logic          WE,
    input  logic [2:0]    ADR,
    input  logic [31:0]   DAT_I,
    output logic [31:0]   DAT_O,
    output logic          ACK,
    output logic [W-1:0]  dout
);

    localparam logic [CW-1:0] PLEN_RST = CW'(PULSE_DEF);

    localparam logic [2:0] ADR_DATA  = 3'd0;
    localparam logic [2:0] ADR_SET   = 3'd1;
    localparam logic [2:0] ADR_CLR   = 3'd2;
    localparam logic [2:0] ADR_TOG   = 3'd3;
    localparam logic [2:0] ADR_PLEN  = 3'd4;
    localparam logic [2:0] ADR_PULSE = 3'd5;

    logic                   ack_reg;
    logic                   ack_next;
    logic [31:0]            dat_o_reg;
    logic [31:0]            dat_o_next;
    logic [W-1:0]           dout_reg;
    logic [W-1:0]           dout_next;
    logic [CW-1:0]          plen_reg;
    logic [CW-1:0]          plen_next;
    logic [W-1:0][CW-1:0]   cnt_reg;
    logic [W-1:0][CW-1:0]   cnt_next;
    logic [W-1:0]           active;
    logic [31:0]            rd_word;

    logic acc;
    logic wr_en;
    logic rd_en;
    logic wr_data;
    logic wr_set;
    logic wr_clr;
    logic wr_tog;
    logic wr_plen;
    logic pulse_load;

    // Upper data bits are ignored when W or CW is narrower than the bus.
    logic unused_dat;
    assign unused_dat = ^DAT_I;

    // ACK itself blocks acceptance, so a held request acks every other cycle.
    assign acc   = CYC & STB & ~ack_reg;
    assign wr_en = acc & WE;
    assign rd_en = acc & ~WE;

    assign wr_data    = wr_en && (ADR == ADR_DATA);
    assign wr_set     = wr_en && (ADR == ADR_SET);
    assign wr_clr     = wr_en && (ADR == ADR_CLR);
    assign wr_tog     = wr_en && (ADR == ADR_TOG);
    assign wr_plen    = wr_en && (ADR == ADR_PLEN);
    assign pulse_load = wr_en && (ADR == ADR_PULSE) && (plen_reg != '0);

    assign ack_next = acc;

    // Per-bit output and pulse counter; any write selecting a bit overrides
    // that bit's expiry in the same cycle.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            logic          sel;
            logic          dout_b;
            logic [CW-1:0] cnt_b;

            assign sel = DAT_I[gi];

            always_comb begin
                dout_b = dout_reg[gi];
                cnt_b  = cnt_reg[gi];
                if (wr_data) begin
                    dout_b = DAT_I[gi];
                    cnt_b  = '0;
                end else if (wr_set && sel) begin
                    dout_b = 1'b1;
                    cnt_b  = '0;
                end else if (wr_clr && sel) begin
                    dout_b = 1'b0;
                    cnt_b  = '0;
                end else if (wr_tog && sel) begin
                    dout_b = ~dout_reg[gi];
                    cnt_b  = '0;
                end else if (pulse_load && sel) begin
                    dout_b = 1'b1;
                    cnt_b  = plen_reg;
                end else if (cnt_reg[gi] == CW'(1)) begin
                    dout_b = 1'b0;
                    cnt_b  = '0;
                end else if (cnt_reg[gi] != '0) begin
                    cnt_b = cnt_reg[gi] - CW'(1);
                end
            end

            assign dout_next[gi] = dout_b;
            assign cnt_next[gi]  = cnt_b;
            assign active[gi]    = (cnt_reg[gi] != '0);
        end
    endgenerate

    assign plen_next = wr_plen ? DAT_I[CW-1:0] : plen_reg;

    always_comb begin
        rd_word = '0;
        case (ADR)
            ADR_DATA, ADR_SET, ADR_CLR, ADR_TOG: rd_word[W-1:0] = dout_reg;
            ADR_PLEN:                            rd_word[CW-1:0] = plen_reg;
            ADR_PULSE:                           rd_word[W-1:0] = active;
            default:                             rd_word = '0;
        endcase
    end

    assign dat_o_next = rd_en ? rd_word : dat_o_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ack_reg   <= 1'b0;
            dat_o_reg <= '0;
            dout_reg  <= '0;
            plen_reg  <= PLEN_RST;
            cnt_reg   <= '0;
        end else begin
            ack_reg   <= ack_next;
            dat_o_reg <= dat_o_next;
            dout_reg  <= dout_next;
            plen_reg  <= plen_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign ACK   = ack_reg;
    assign DAT_O = dat_o_reg;
    assign dout  = dout_reg;

endmodule

// File: doc/dev_gpo_pulse.md
Name: dev_gpo_pulse

Overview:
Wishbone-slave general-purpose output port, the parametrised successor to the basic GPO device. It adds atomic per-bit set, clear and toggle writes, timed auto-clearing pulse outputs with a programmable length, and full register readback. It sits on the MMIO bus as a memory-mapped slot and drives W external digital outputs.

Parameters:
W, 8, number of output bits (1..32)
CW, 16, pulse-length counter width (1..32)
PULSE_DEF, 1000, reset value of PLEN; must fit in CW bits

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
CYC  input  1  Wishbone cycle
STB  input  1  Wishbone strobe
WE  input  1  write enable (1 = write)
ADR  input  3  word address within slot
DAT_I  input  32  write data
DAT_O  output  32  registered read data
ACK  output  1  transfer acknowledge
dout  output  W  external digital outputs

Behaviour:
- Reset (RST_N low, asynchronous), all cleared: dout=0, ACK=0, DAT_O=0, all pulse counters=0; PLEN=PULSE_DEF.
- Accept condition: acc = CYC & STB & ~ACK. On an accepted cycle, ACK=1 on the next cycle; otherwise ACK=0. ACK is therefore a one-cycle pulse per transfer, and back-to-back transfers alternate.
- Writes (acc & WE) take effect at the accepting edge, so dout changes with the same latency as ACK (1 cycle).
- Reads (acc & ~WE) return the register value sampled in the accept cycle, loaded into DAT_O. DAT_O holds its value between reads.
- Only DAT_I[W-1:0] is used for bit registers and DAT_I[CW-1:0] for PLEN. Unused read bits are 0.
- Register map (ADR):
  - 0 DATA (RW): dout <= DAT_I; cancels all pulses. Read returns dout.
  - 1 SET (W): dout |= DAT_I. Read returns dout.
  - 2 CLR (W): dout &= ~DAT_I. Read returns dout.
  - 3 TOG (W): dout ^= DAT_I. Read returns dout.
  - 4 PLEN (RW): pulse length in cycles.
  - 5 PULSE (W): for each i with DAT_I[i]=1, dout[i] <= 1 and cnt[i] <= PLEN. Read returns the active-pulse mask (cnt[i]!=0).
  - 6, 7: reserved. Reads return 0; writes are ignored but still ACKed.
- SET, CLR and TOG cancel the pending pulse (cnt[i] <= 0) only on bits selected by DAT_I. Unselected bits keep counting.
- Pulse counter, per bit, when no write targets that bit:
  - If cnt[i] > 1: decrement.
  - If cnt[i] == 1: cnt[i] <= 0 and dout[i] <= 0.
  - Result: dout[i] is high for exactly PLEN cycles after the write edge.
- PLEN=0: a PULSE write is a no-op for dout and the counters.
- Re-pulsing an active bit reloads its counter with the current PLEN (retrigger).
- A PLEN write does not affect counters already running.
- Simultaneous events: a bus write to bit i wins over expiry of bit i in the same cycle.
- Reset mid-pulse: outputs and counters clear immediately; no residual pulse after RST_N rises.
- ACK asserts even if CYC drops during the ACK cycle. There is no error or stall response.

Test Plan:
1. Reset: hold RST_N=0 -> dout=0, ACK=0, DAT_O=0. Read ADR4 -> 1000.
2. Write DATA=0xA5, then SET 0x0F, CLR 0x81, TOG 0xFF -> dout goes 0xA5 → 0xAF → 0x2E → 0xD1. Read ADR0 returns 0xD1. Each write gives exactly one ACK cycle.
3. PLEN=5, PULSE 0x01 -> dout[0] high exactly 5 cycles. ADR5 reads 0x01 while active and 0x00 after expiry.
4. PLEN=10, PULSE 0x03, then CLR 0x01 at cycle 3 -> bit0 drops immediately; bit1 still drops at cycle 10. Retrigger bit1 at cycle 8 -> bit1 stays high until cycle 18.
5. CLR on bit0 issued in the exact cycle its counter hits 1 -> dout[0]=0, cnt=0, no double event. With PLEN=0, PULSE 0xFF -> dout unchanged.
6. CYC/STB held high for 6 cycles with WE=0 -> ACK pattern 0,1,0,1,0,1. Assert RST_N=0 mid-pulse -> dout=0 immediately, and stays 0 after release.
